// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Single-input, multi-output stream router. Whole packets (first beat through
//   the beat flagged last) are steered to the output named by the dest field of
//   the first beat. Packets addressed to a non-existent output are consumed
//   and discarded. Each output owns a 2-entry {data, last} FIFO, so the
//   m_data_o / m_last_o / m_valid_o outputs come straight from registers.
//
// Optional feature (macro STREAM_DEMUX_DROP_CNT_EN):
//   Adds drop_cnt_o, a saturating 16-bit count of discarded packets.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous, active-high reset
//   s_data_i    input beat payload
//   s_dest_i    target output, sampled on the first beat of a packet only
//   s_last_i    final beat of packet
//   s_valid_i   input beat valid
//   s_ready_o   input beat accepted when s_valid_i & s_ready_o
//   m_data_o    per-output payload (FIFO head)
//   m_last_o    per-output last flag (FIFO head)
//   m_valid_o   per-output valid (FIFO not empty)
//   m_ready_i   per-output ready (pops the FIFO head)
//   drop_cnt_o  discarded-packet count (only with STREAM_DEMUX_DROP_CNT_EN)
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter  int T_DATA_WIDTH = 8,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_DEST_WIDTH-1:0] s_dest_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [M_DATA_COUNT-1:0],
    output logic [M_DATA_COUNT-1:0] m_last_o,
    output logic [M_DATA_COUNT-1:0] m_valid_o,
    input  logic [M_DATA_COUNT-1:0] m_ready_i
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]             drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,   // no packet open, target comes from s_dest_i
        PASS,   // packet open to a valid output, target is the locked dest
        DROP    // packet open to a non-existent output
    } state_t;

    typedef struct packed {
        logic                    last;
        logic [T_DATA_WIDTH-1:0] data;
    } beat_t;

    state_t                  state;
    logic [T_DEST_WIDTH-1:0] lock;

    beat_t                   mem    [M_DATA_COUNT][2];
    logic [M_DATA_COUNT-1:0] rd_ptr;
    logic [1:0]              count  [M_DATA_COUNT];

    logic                    dest_ok;
    logic                    route_ok;
    logic [T_DEST_WIDTH-1:0] route_idx;
    logic                    sel_full;
    logic                    accept;
    logic [M_DATA_COUNT-1:0] push;
    logic [M_DATA_COUNT-1:0] pop;

    assign dest_ok = 32'(s_dest_i) < M_DATA_COUNT;

    // Where the current beat goes. Only registered state and s_dest_i feed
    // s_ready_o; m_ready_i is deliberately kept out of this path, so a full
    // buffer being popped this cycle still refuses the push.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        route_ok  = 1'b0;
        route_idx = s_dest_i;
        sel_full  = 1'b0;
        unique case (state)
            IDLE: begin
                route_ok  = dest_ok;
                route_idx = s_dest_i;
            end
            PASS: begin
                route_ok  = 1'b1;
                route_idx = lock;
            end
            default: ;  // DROP: beat is swallowed
        endcase
        // Loop-select avoids indexing count[] with an out-of-range dest.
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            if (route_idx == T_DEST_WIDTH'(i) && count[i] == 2'd2) sel_full = 1'b1;
        end
    end

    assign s_ready_o = !rst && !(route_ok && sel_full);
    assign accept    = s_valid_i && s_ready_o;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            push[i] = accept && route_ok && (route_idx == T_DEST_WIDTH'(i));
            // A ready with nothing buffered is ignored.
            pop[i]  = m_ready_i[i] && (count[i] != 2'd0);
        end
    end

    always_comb begin
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            m_data_o[i]  = mem[i][rd_ptr[i]].data;
            m_last_o[i]  = mem[i][rd_ptr[i]].last;
            m_valid_o[i] = count[i] != 2'd0;
        end
    end

    // Per-output 2-entry FIFOs. The write slot is the one after the head when
    // one entry is held, else the head slot itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M_DATA_COUNT; i++) begin
                count[i]  <= 2'd0;
                rd_ptr[i] <= 1'b0;
                // NOTE: storage is reset too because its head drives m_data_o/m_last_o, which must read 0 out of reset.
                mem[i][0] <= '0;
                mem[i][1] <= '0;
            end
        end else begin
            for (int i = 0; i < M_DATA_COUNT; i++) begin
                if (push[i]) begin
                    // NOTE: non-blocking assignments keep all state updates relative to the pre-edge values.
                    mem[i][rd_ptr[i] ^ count[i][0]] <= '{last: s_last_i, data: s_data_i};
                end
                if (pop[i]) rd_ptr[i] <= ~rd_ptr[i];
                if (push[i] && !pop[i])      count[i] <= count[i] + 2'd1;
                else if (pop[i] && !push[i]) count[i] <= count[i] - 2'd1;
            end
        end
    end

    // Packet tracking: advances only on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lock  <= '0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (!s_last_i) begin
                        if (dest_ok) begin
                            state <= PASS;
                            lock  <= s_dest_i;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                default: begin
                    if (s_last_i) state <= IDLE;
                end
            endcase
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic dropped;

    // Counted once per packet, on its accepted last beat.
    assign dropped = accept && s_last_i &&
                     ((state == IDLE && !dest_ok) || state == DROP);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_o <= 16'd0;
        end else if (dropped && drop_cnt_o != 16'hFFFF) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Self-checking bench for stream_demux. A packet-level reference model keeps
//   one queue per output holding the beats that should currently be buffered;
//   expected s_ready_o, m_valid_o and head data/last follow from the queue
//   sizes and heads. Directed scenarios run first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_stream_demux;

    localparam int W  = 8;
    localparam int M  = 3;
    localparam int DW = $clog2(M);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_data_i;
    logic [DW-1:0] s_dest_i;
    logic          s_last_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [W-1:0]  m_data_o [M-1:0];
    logic [M-1:0]  m_last_o;
    logic [M-1:0]  m_valid_o;
    logic [M-1:0]  m_ready_i;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    always #5 clk = ~clk;

    stream_demux #(.T_DATA_WIDTH(W), .M_DATA_COUNT(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_dest_i  (s_dest_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt_o(drop_cnt_o)
`endif
    );

    // Reference model state
    logic [W:0] exp_q [M][$];   // {last, data} beats expected in each buffer
    bit         pkt_open;
    int         pkt_tgt;        // -1 means the open packet is being dropped
    bit         zero_data [M];  // output has not received a beat since reset
    bit         model_known;
    int         exp_drops;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int target_of(input logic [DW-1:0] d);
        if (pkt_open) return pkt_tgt;
        return (int'(d) < M) ? int'(d) : -1;
    endfunction

    // One clock: drive inputs, check outputs against the model, update the model.
    task automatic step(input bit r, input bit v, input logic [W-1:0] d,
                        input logic [DW-1:0] dst, input bit l,
                        input logic [M-1:0] rdy, output bit acc);
        int tgt;
        bit exp_rdy;
        @(negedge clk);
        rst       = r;
        s_valid_i = v;
        s_data_i  = d;
        s_dest_i  = dst;
        s_last_i  = l;
        m_ready_i = rdy;
        #1;
        tgt     = target_of(dst);
        exp_rdy = !r && (tgt < 0 || exp_q[tgt].size() < 2);
        if (model_known) begin
            for (int i = 0; i < M; i++) begin
                check($sformatf("valid%0d", i), 32'(m_valid_o[i]), 32'(exp_q[i].size() != 0));
                if (exp_q[i].size() != 0) begin
                    check($sformatf("data%0d", i), 32'(m_data_o[i]), 32'(exp_q[i][0][W-1:0]));
                    check($sformatf("last%0d", i), 32'(m_last_o[i]), 32'(exp_q[i][0][W]));
                end else if (zero_data[i]) begin
                    check($sformatf("rst_data%0d", i), 32'(m_data_o[i]), 32'd0);
                    check($sformatf("rst_last%0d", i), 32'(m_last_o[i]), 32'd0);
                end
            end
`ifdef STREAM_DEMUX_DROP_CNT_EN
            check("drop_cnt", 32'(drop_cnt_o), 32'(exp_drops));
`endif
        end
        check("s_ready", 32'(s_ready_o), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < M; i++) begin
                exp_q[i].delete();
                zero_data[i] = 1'b1;
            end
            pkt_open    = 1'b0;
            exp_drops   = 0;
            model_known = 1'b1;
        end else begin
            for (int i = 0; i < M; i++) begin
                if (rdy[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
            end
            if (acc) begin
                if (tgt >= 0) begin
                    exp_q[tgt].push_back({l, d});
                    zero_data[tgt] = 1'b0;
                end else if (l && exp_drops < 65535) begin
                    exp_drops++;
                end
                if (l) pkt_open = 1'b0;
                else if (!pkt_open) begin
                    pkt_open = 1'b1;
                    pkt_tgt  = tgt;
                end
            end
        end
    endtask

    // Offer one beat until accepted, within a cycle budget.
    task automatic send(input logic [DW-1:0] dst, input logic [W-1:0] d,
                        input bit l, input logic [M-1:0] rdy);
        bit acc;
        int n = 0;
        do begin
            step(1'b0, 1'b1, d, dst, l, rdy, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic [M-1:0] rdy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, rdy, acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        n_checks    = 0;
        n_fail      = 0;
        model_known = 1'b0;
        pkt_open    = 1'b0;
        pkt_tgt     = -1;
        exp_drops   = 0;
        rst = 1'b1; s_valid_i = 1'b0; s_data_i = '0; s_dest_i = '0;
        s_last_i = 1'b0; m_ready_i = '1;

        // Reset, then idle: nothing valid, ready high, outputs zero.
        step(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111, acc);
        step(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111, acc);
        idle(2, 3'b111);

        // Single beat to output 0, visible the next cycle.
        send(2'd0, 8'hA5, 1'b1, 3'b111);
        idle(2, 3'b111);

        // 4-beat packet to 1; later beats carry dest 2 and must not split it.
        send(2'd1, 8'h11, 1'b0, 3'b111);
        send(2'd2, 8'h12, 1'b0, 3'b111);
        send(2'd2, 8'h13, 1'b0, 3'b111);
        send(2'd2, 8'h14, 1'b1, 3'b111);
        idle(2, 3'b111);

        // Output 0 stalled: two beats buffer, third is refused until a pop.
        send(2'd0, 8'h21, 1'b0, 3'b110);
        send(2'd0, 8'h22, 1'b0, 3'b110);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h23, 2'd0, 1'b1, 3'b110, acc);
        send(2'd0, 8'h23, 1'b1, 3'b111);
        idle(3, 3'b111);

        // 2-beat packet to non-existent output 3: swallowed.
        send(2'd3, 8'h31, 1'b0, 3'b111);
        send(2'd3, 8'h32, 1'b1, 3'b111);
        idle(2, 3'b111);

        // Back-to-back single-beat packets.
        send(2'd0, 8'h40, 1'b1, 3'b111);
        send(2'd1, 8'h41, 1'b1, 3'b111);
        send(2'd2, 8'h42, 1'b1, 3'b111);
        send(2'd0, 8'h43, 1'b1, 3'b111);
        idle(2, 3'b111);

        // Reset mid-packet with two beats held on output 2.
        send(2'd2, 8'h51, 1'b0, 3'b011);
        send(2'd2, 8'h52, 1'b0, 3'b011);
        step(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b011, acc);
        idle(2, 3'b011);
        send(2'd2, 8'h61, 1'b0, 3'b111);
        send(2'd2, 8'h62, 1'b1, 3'b111);
        idle(2, 3'b111);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 7,
                 W'($urandom),
                 DW'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0,
                 (c % 500 < 250) ? M'($urandom) : M'($urandom | $urandom),
                 acc);
        end
        idle(4, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
